mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Responder side of the control unit's MEM command bus: decodes the 3-bit MEM code and executes instruction-memory fetches into MIDR, data-memory reads into MDDR and data-memory writes from MDDR.
- Sits between the control unit and the synchronous instruction and data memories.
- Hides the memories' read latency behind a busy/done handshake.
- Owns the MIDR and MDDR registers.

Parameters:
- AW, 16, instruction and data address width.
- RD_LAT, 2, memory read latency in clock edges; legal range 1..15.

Ports:
- clock  in  1  single clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MEM  in  3  command code: 0 none, 1 fetch to MIDR, 2 data read to MDDR, 3 data write, 4..7 reserved.
- PC  in  AW  instruction address.
- AR  in  AW  data address.
- mddr_load  in  1  load MDDR from mddr_din (AC to MDDR transfer).
- mddr_din  in  8  data for mddr_load.
- im_addr  out  AW  instruction memory address.
- im_rdata  in  8  instruction memory read data.
- dm_addr  out  AW  data memory address.
- dm_wdata  out  8  data memory write data.
- dm_we  out  1  data memory write enable.
- dm_rdata  in  8  data memory read data.
- MIDR  out  8  instruction register.
- MDDR  out  8  data register.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- cmd_err  out  1  sticky flag: reserved code received, or command/load dropped.

Behaviour:
- Reset (synchronous, active-high): every output is 0, including MIDR, MDDR, im_addr, dm_addr, dm_wdata, dm_we, busy, done and cmd_err. State returns to IDLE. The mem_prev register (the previous sampled MEM value) is 0.
- Reset mid-operation aborts the operation: no capture, no done, dm_we is 0 on the next cycle.
- Command acceptance: a command is accepted on the edge where MEM != 0, mem_prev == 0 and the state is IDLE. This rising-edge detect means a level-held MEM code executes exactly once. mem_prev updates on every edge.
- A new nonzero MEM rising edge while busy: the command is ignored and cmd_err is set.
- MEM codes 4..7 on the rising edge: no operation, cmd_err is set.
- States: IDLE, RD_WAIT, WR.
- Read (code 1 or 2), timing measured from the accepting edge E0:
  - At E0: im_addr <= PC (code 1) or dm_addr <= AR (code 2). Counter cnt <= RD_LAT. busy <= 1. Next state RD_WAIT.
  - In RD_WAIT: cnt decrements each edge.
  - On edge E(RD_LAT): MIDR <= im_rdata (code 1) or MDDR <= dm_rdata (code 2). busy <= 0. done <= 1. Next state IDLE.
  - done is high for exactly one cycle.
  - With RD_LAT = 1, the capture occurs at E1.
- Write (code 3):
  - At E0: dm_addr <= AR, dm_wdata <= MDDR, dm_we <= 1, busy <= 1. Next state WR.
  - At E1: dm_we <= 0, busy <= 0, done <= 1. Next state IDLE.
  - dm_we is high for exactly one cycle.
- mddr_load:
  - When no read into MDDR completes on the same edge: MDDR <= mddr_din on that edge.
  - mddr_load on the same edge as the E0 of a write: MDDR updates, but dm_wdata takes the old MDDR value.
  - Collision with a code-2 capture edge: the capture wins, the load is dropped and cmd_err is set.
- cmd_err clears only on reset.
- im_addr and dm_addr hold their last values while idle.

Test Plan:
- Fetch: reset, PC=16'h0010, im_rdata=8'hA5, RD_LAT=2, MEM 0->1 -> busy high for 2 cycles; MIDR=8'hA5 at E2; done pulses once; im_addr=16'h0010.
- Data read: AR=16'h0200, dm_rdata=8'h3C, MEM 0->2 held for 5 cycles -> MDDR=8'h3C at E2; exactly one done; no second command is accepted.
- Load then write: mddr_load with mddr_din=8'h7E, then MEM 0->3 with AR=16'h0040 -> dm_we high for exactly 1 cycle with dm_addr=16'h0040 and dm_wdata=8'h7E; done at E1.
- Overlap and reserved code: issue MEM=2, then MEM 0->1 while busy -> the fetch is ignored and cmd_err=1. After reset, MEM 0->5 -> no memory activity, cmd_err=1.
- Collision: mddr_load=1 with mddr_din=8'h11 on the code-2 capture edge where dm_rdata=8'h22 -> MDDR=8'h22 and cmd_err=1.
- Reset mid-read: assert reset at E1 of a read with RD_LAT=2 -> no done; MIDR and MDDR are 0; state IDLE; the next MEM rising edge is accepted normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: responder for the control unit's MEM command bus.
// Decodes the 3-bit MEM code and runs instruction fetches into MIDR, data
// reads into MDDR and data writes from MDDR against synchronous memories.
// The memories' read latency is hidden behind a busy/done handshake.
module mem_access_unit #(
  parameter int AW     = 16,
  parameter int RD_LAT = 2    // read latency in clock edges, 1..15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [2:0]    MEM,
  input  logic [AW-1:0] PC,
  input  logic [AW-1:0] AR,
  input  logic          mddr_load,
  input  logic [7:0]    mddr_din,
  output logic [AW-1:0] im_addr,
  input  logic [7:0]    im_rdata,
  output logic [AW-1:0] dm_addr,
  output logic [7:0]    dm_wdata,
  output logic          dm_we,
  input  logic [7:0]    dm_rdata,
  output logic [7:0]    MIDR,
  output logic [7:0]    MDDR,
  output logic          busy,
  output logic          done,
  output logic          cmd_err
);

  // Counter preload; 4 bits covers the full 1..15 latency range.
  localparam logic [3:0] LAT = 4'(RD_LAT);

  localparam logic [2:0] MEM_NONE  = 3'd0;
  localparam logic [2:0] MEM_FETCH = 3'd1;
  localparam logic [2:0] MEM_READ  = 3'd2;
  localparam logic [2:0] MEM_WRITE = 3'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_mem_prev;
  logic [3:0]  r_cnt;
  logic        r_is_fetch;   // 1: pending read targets MIDR, 0: MDDR

  logic        w_rise;
  logic        w_accept_rd;
  logic        w_accept_wr;
  logic        w_capture;
  logic        w_capture_mddr;
  logic        w_finish_wr;
  logic        w_load_ok;
  logic        w_err;

  // Next-state and per-edge control decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_accept_rd    = 1'b0;
    w_accept_wr    = 1'b0;
    w_capture      = 1'b0;
    w_finish_wr    = 1'b0;
    w_err          = 1'b0;
    // A command is a 0 -> nonzero transition, so a held code runs only once.
    w_rise         = (MEM != MEM_NONE) && (r_mem_prev == MEM_NONE);

    case (r_state)
      IDLE: begin
        if (w_rise) begin
          case (MEM)
            MEM_FETCH, MEM_READ: begin
              w_accept_rd = 1'b1;
              w_state_nxt = RD_WAIT;
            end
            MEM_WRITE: begin
              w_accept_wr = 1'b1;
              w_state_nxt = WR;
            end
            default: w_err = 1'b1;   // reserved codes 4..7
          endcase
        end
      end
      RD_WAIT: begin
        // Any new command while a read is in flight is dropped.
        if (w_rise) w_err = 1'b1;
        // cnt reaches 1 on the RD_LAT-th edge after acceptance.
        if (r_cnt == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WR: begin
        if (w_rise) w_err = 1'b1;
        w_finish_wr = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // A data-read capture owns MDDR on its edge; a coinciding load is lost.
    w_capture_mddr = w_capture && !r_is_fetch;
    w_load_ok      = mddr_load && !w_capture_mddr;
    if (mddr_load && w_capture_mddr) w_err = 1'b1;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Handshake, latency counter, write strobe and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_prev <= 3'd0;
      r_cnt      <= 4'd0;
      r_is_fetch <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dm_we      <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      r_mem_prev <= MEM;
      done       <= 1'b0;
      if (r_state == RD_WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_accept_rd) begin
        r_is_fetch <= (MEM == MEM_FETCH);
        r_cnt      <= LAT;
        busy       <= 1'b1;
      end
      if (w_accept_wr) begin
        dm_we <= 1'b1;
        busy  <= 1'b1;
      end
      if (w_capture || w_finish_wr) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (w_finish_wr) dm_we <= 1'b0;
      if (w_err) cmd_err <= 1'b1;
    end
  end

  // Address, write-data and the MIDR/MDDR registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      im_addr  <= '0;
      dm_addr  <= '0;
      dm_wdata <= 8'd0;
      MIDR     <= 8'd0;
      MDDR     <= 8'd0;
    end else begin
      if (w_accept_rd) begin
        if (MEM == MEM_FETCH) im_addr <= PC;
        else                  dm_addr <= AR;
      end
      if (w_accept_wr) begin
        dm_addr  <= AR;
        dm_wdata <= MDDR;     // pre-edge MDDR, even if a load lands now
      end
      if (w_capture && r_is_fetch) MIDR <= im_rdata;
      if (w_capture_mddr)          MDDR <= dm_rdata;
      else if (w_load_ok)          MDDR <= mddr_din;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    MEM;
  logic [AW-1:0] PC, AR;
  logic          mddr_load;
  logic [7:0]    mddr_din;
  logic [AW-1:0] im_addr, dm_addr;
  logic [7:0]    im_rdata, dm_rdata, dm_wdata;
  logic          dm_we;
  logic [7:0]    MIDR, MDDR;
  logic          busy, done, cmd_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done;

  mem_access_unit #(.AW(AW), .RD_LAT(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .MEM      (MEM),
    .PC       (PC),
    .AR       (AR),
    .mddr_load(mddr_load),
    .mddr_din (mddr_din),
    .im_addr  (im_addr),
    .im_rdata (im_rdata),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata),
    .MIDR     (MIDR),
    .MDDR     (MDDR),
    .busy     (busy),
    .done     (done),
    .cmd_err  (cmd_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; MEM = 3'd0; PC = '0; AR = '0;
    mddr_load = 1'b0; mddr_din = 8'd0; im_rdata = 8'd0; dm_rdata = 8'd0;
    tick(); tick();
    chk("rst_midr", 32'(MIDR), 32'h0);
    chk("rst_mddr", 32'(MDDR), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err",  32'(cmd_err), 32'h0);
    chk("rst_we",   32'(dm_we), 32'h0);
    chk("rst_imad", 32'(im_addr), 32'h0);
    chk("rst_dmad", 32'(dm_addr), 32'h0);
    chk("rst_wdat", 32'(dm_wdata), 32'h0);
    reset = 1'b0;
    tick();

    // Fetch: E0 accept, capture at E2.
    PC = 16'h0010; im_rdata = 8'hA5; MEM = 3'd1;
    tick();
    chk("f_e0_busy", 32'(busy), 32'h1);
    chk("f_e0_imad", 32'(im_addr), 32'h0010);
    chk("f_e0_done", 32'(done), 32'h0);
    MEM = 3'd0;
    tick();
    chk("f_e1_busy", 32'(busy), 32'h1);
    chk("f_e1_midr", 32'(MIDR), 32'h0);
    tick();
    chk("f_e2_midr", 32'(MIDR), 32'hA5);
    chk("f_e2_busy", 32'(busy), 32'h0);
    chk("f_e2_done", 32'(done), 32'h1);
    tick();
    chk("f_e3_done", 32'(done), 32'h0);

    // Data read with MEM held for 5 cycles: exactly one done.
    AR = 16'h0200; dm_rdata = 8'h3C; MEM = 3'd2;
    tick();
    chk("r_e0_busy", 32'(busy), 32'h1);
    chk("r_e0_dmad", 32'(dm_addr), 32'h0200);
    n_done = 0;
    for (int i = 1; i < 5; i++) begin
      tick();
      if (done) n_done++;
      if (i == 2) chk("r_e2_mddr", 32'(MDDR), 32'h3C);
      if (i == 4) chk("r_e4_busy", 32'(busy), 32'h0);
    end
    chk("r_done_cnt", 32'(n_done), 32'd1);
    MEM = 3'd0;
    tick();
    chk("r_err", 32'(cmd_err), 32'h0);

    // Load then write.
    mddr_load = 1'b1; mddr_din = 8'h7E;
    tick();
    mddr_load = 1'b0;
    chk("ld_mddr", 32'(MDDR), 32'h7E);
    AR = 16'h0040; MEM = 3'd3;
    tick();
    chk("w_e0_we",   32'(dm_we), 32'h1);
    chk("w_e0_dmad", 32'(dm_addr), 32'h0040);
    chk("w_e0_wdat", 32'(dm_wdata), 32'h7E);
    chk("w_e0_done", 32'(done), 32'h0);
    MEM = 3'd0;
    tick();
    chk("w_e1_we",   32'(dm_we), 32'h0);
    chk("w_e1_done", 32'(done), 32'h1);
    chk("w_e1_busy", 32'(busy), 32'h0);
    tick();
    chk("w_e2_done", 32'(done), 32'h0);

    // Load on the write's E0: write takes old MDDR, MDDR takes new data.
    mddr_load = 1'b1; mddr_din = 8'h99; AR = 16'h0041; MEM = 3'd3;
    tick();
    mddr_load = 1'b0; MEM = 3'd0;
    chk("wl_wdat", 32'(dm_wdata), 32'h7E);
    chk("wl_mddr", 32'(MDDR), 32'h99);
    tick(); tick();

    // Overlap: fetch rising edge during a data read is ignored.
    AR = 16'h0200; dm_rdata = 8'h3C; MEM = 3'd2;
    tick();
    MEM = 3'd0;
    tick();
    PC = 16'h0ABC; im_rdata = 8'hEE; MEM = 3'd1;
    tick();
    chk("ov_err",  32'(cmd_err), 32'h1);
    chk("ov_mddr", 32'(MDDR), 32'h3C);
    chk("ov_done", 32'(done), 32'h1);
    MEM = 3'd0;
    tick(); tick(); tick();
    chk("ov_imad", 32'(im_addr), 32'h0010);
    chk("ov_midr", 32'(MIDR), 32'hA5);
    chk("ov_busy", 32'(busy), 32'h0);

    // Reserved code after reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_err0", 32'(cmd_err), 32'h0);
    tick();
    MEM = 3'd5;
    tick();
    chk("rs_busy", 32'(busy), 32'h0);
    chk("rs_we",   32'(dm_we), 32'h0);
    chk("rs_err",  32'(cmd_err), 32'h1);
    MEM = 3'd0;
    tick();
    chk("rs_done", 32'(done), 32'h0);
    chk("rs_dmad", 32'(dm_addr), 32'h0);

    // Collision: load on the data-read capture edge.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    AR = 16'h0300; dm_rdata = 8'h22; MEM = 3'd2;
    tick();
    MEM = 3'd0;
    tick();
    mddr_load = 1'b1; mddr_din = 8'h11;
    tick();
    mddr_load = 1'b0;
    chk("col_mddr", 32'(MDDR), 32'h22);
    chk("col_err",  32'(cmd_err), 32'h1);
    chk("col_done", 32'(done), 32'h1);

    // Reset at E1 of a fetch aborts it.
    tick();
    PC = 16'h0080; im_rdata = 8'h5A; MEM = 3'd1;
    tick();
    chk("rm_e0_busy", 32'(busy), 32'h1);
    MEM = 3'd0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_busy", 32'(busy), 32'h0);
    chk("rm_midr", 32'(MIDR), 32'h0);
    chk("rm_mddr", 32'(MDDR), 32'h0);
    chk("rm_err",  32'(cmd_err), 32'h0);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("rm_nodone", 32'(n_done), 32'd0);
    chk("rm_midr2",  32'(MIDR), 32'h0);
    MEM = 3'd1;
    tick();
    chk("rm_re_busy", 32'(busy), 32'h1);
    chk("rm_re_imad", 32'(im_addr), 32'h0080);
    MEM = 3'd0;
    tick(); tick();
    chk("rm_re_midr", 32'(MIDR), 32'h5A);
    chk("rm_re_done", 32'(done), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
